// File: rtl/multicycle_pkg.sv
// Shared encodings for the multicycle control unit: FSM states, ALU codes,
// data-processing cmd values, condition codes and datapath select values.
package multicycle_pkg;

    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_FETCH    = 4'd1;
    localparam logic [3:0] S_DECODE   = 4'd2;
    localparam logic [3:0] S_MEMADR   = 4'd3;
    localparam logic [3:0] S_MEMREAD  = 4'd4;
    localparam logic [3:0] S_MEMWB    = 4'd5;
    localparam logic [3:0] S_MEMWRITE = 4'd6;
    localparam logic [3:0] S_EXECR    = 4'd7;
    localparam logic [3:0] S_EXECI    = 4'd8;
    localparam logic [3:0] S_ALUWB    = 4'd9;
    localparam logic [3:0] S_BRANCH   = 4'd10;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;
    localparam logic [1:0] OP_NOP = 2'b11;

    localparam logic [1:0] IMM8  = 2'b00;
    localparam logic [1:0] IMM12 = 2'b01;
    localparam logic [1:0] IMM24 = 2'b10;

    localparam logic [1:0] REGSRC_A1_PC = 2'b01;
    localparam logic [1:0] REGSRC_A2_RD = 2'b10;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_MEM    = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    typedef enum logic [3:0] {
        COND_EQ = 4'b0000, COND_NE = 4'b0001, COND_CS = 4'b0010, COND_CC = 4'b0011,
        COND_MI = 4'b0100, COND_PL = 4'b0101, COND_VS = 4'b0110, COND_VC = 4'b0111,
        COND_HI = 4'b1000, COND_LS = 4'b1001, COND_GE = 4'b1010, COND_LT = 4'b1011,
        COND_GT = 4'b1100, COND_LE = 4'b1101, COND_AL = 4'b1110, COND_NV = 4'b1111
    } cond_e;

    // Returns {valid, alu_code}; unsupported cmds come back invalid with ADD.
    function automatic logic [2:0] cmd_decode(input logic [3:0] cmd);
        case (cmd)
            CMD_ADD: cmd_decode = {1'b1, ALU_ADD};
            CMD_SUB: cmd_decode = {1'b1, ALU_SUB};
            CMD_AND: cmd_decode = {1'b1, ALU_AND};
            CMD_ORR: cmd_decode = {1'b1, ALU_ORR};
            default: cmd_decode = {1'b0, ALU_ADD};
        endcase
    endfunction

endpackage

// File: rtl/multicycle_control_cond_check.sv
// Condition-field evaluator against latched NZCV. Only instantiated when
// COND_EXEC_EN is defined.
module cond_check
    import multicycle_pkg::*;
(
    input  logic [3:0] cond_i,
    input  logic [3:0] flags_i,
    output logic       cond_ex_o
);

    logic n, z, c, v;
    assign {n, z, c, v} = flags_i;

    always_comb begin
        cond_ex_o = 1'b0;
        case (cond_i)
            COND_EQ: cond_ex_o = z;
            COND_NE: cond_ex_o = ~z;
            COND_CS: cond_ex_o = c;
            COND_CC: cond_ex_o = ~c;
            COND_MI: cond_ex_o = n;
            COND_PL: cond_ex_o = ~n;
            COND_VS: cond_ex_o = v;
            COND_VC: cond_ex_o = ~v;
            COND_HI: cond_ex_o = c & ~z;
            COND_LS: cond_ex_o = ~c | z;
            COND_GE: cond_ex_o = (n == v);
            COND_LT: cond_ex_o = (n != v);
            COND_GT: cond_ex_o = ~z & (n == v);
            COND_LE: cond_ex_o = z | (n != v);
            COND_AL: cond_ex_o = 1'b1;
            default: cond_ex_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle ARM-subset control FSM. Define COND_EXEC_EN to get the Flags
// register and condition evaluation; otherwise everything runs as AL.
module multicycle_control
    import multicycle_pkg::*;
(
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [31:0] Instr,
    input  logic [3:0]  ALU_Flags,
    input  logic        MemReady,
    output logic        MemReq,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic        PCWrite,
    output logic        AdrSrc,
    output logic        RegWrite,
    output logic [1:0]  RegSrc,
    output logic [1:0]  ImmSrc,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ALU_Code,
    output logic [1:0]  ResultSrc,
    output logic [3:0]  Flags
);

    logic [3:0] state_q, state_d;
    logic [1:0] op;
    logic       i_bit, u_bit, l_bit;
    logic       cmd_ok;
    logic [1:0] cmd_alu;
    logic       cond_ex;
    logic       unused_bits;

    assign op    = Instr[27:26];
    assign i_bit = Instr[25];
    assign u_bit = Instr[23];
    assign l_bit = Instr[20];
    assign {cmd_ok, cmd_alu} = cmd_decode(Instr[24:21]);

    always_comb begin
        state_d   = state_q;
        MemReq    = 1'b0;
        MemWrite  = 1'b0;
        IRWrite   = 1'b0;
        PCWrite   = 1'b0;
        AdrSrc    = 1'b0;
        RegWrite  = 1'b0;
        RegSrc    = 2'b00;
        ImmSrc    = IMM8;
        ALUSrcA   = 1'b0;
        ALUSrcB   = SRCB_RD2;
        ALU_Code  = ALU_ADD;
        ResultSrc = RES_ALUOUT;
        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                MemReq   = 1'b1;
                ALUSrcA  = 1'b1;
                ALUSrcB  = SRCB_FOUR;
                if (MemReady) begin
                    IRWrite = 1'b1;
                    PCWrite = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                case (op)
                    OP_MEM: begin ImmSrc = IMM12; RegSrc = REGSRC_A2_RD; end
                    OP_BR:  begin ImmSrc = IMM24; RegSrc = REGSRC_A1_PC; end
                    default: ;
                endcase
                if (!cond_ex) state_d = S_FETCH;
                else begin
                    case (op)
                        OP_DP:   state_d = i_bit ? S_EXECI : S_EXECR;
                        OP_MEM:  state_d = S_MEMADR;
                        OP_BR:   state_d = S_BRANCH;
                        OP_NOP:  state_d = S_FETCH;
                        default: state_d = S_FETCH;
                    endcase
                end
            end
            S_EXECR, S_EXECI: begin
                ALU_Code = cmd_alu;
                if (state_q == S_EXECI) ALUSrcB = SRCB_IMM;
                state_d = cmd_ok ? S_ALUWB : S_FETCH;
            end
            S_ALUWB: begin
                RegWrite  = 1'b1;
                ResultSrc = RES_ALUOUT;
                state_d   = S_FETCH;
            end
            S_MEMADR: begin
                ImmSrc   = IMM12;
                ALUSrcB  = SRCB_IMM;
                ALU_Code = u_bit ? ALU_ADD : ALU_SUB;
                state_d  = l_bit ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                MemReq = 1'b1;
                AdrSrc = 1'b1;
                if (MemReady) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                RegWrite  = 1'b1;
                ResultSrc = RES_MEM;
                state_d   = S_FETCH;
            end
            S_MEMWRITE: begin
                MemReq   = 1'b1;
                MemWrite = 1'b1;
                AdrSrc   = 1'b1;
                if (MemReady) state_d = S_FETCH;
            end
            S_BRANCH: begin
                ImmSrc    = IMM24;
                ALUSrcA   = 1'b1;
                ALUSrcB   = SRCB_IMM;
                ResultSrc = RES_ALU;
                PCWrite   = 1'b1;
                state_d   = S_FETCH;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

`ifdef COND_EXEC_EN
    logic [3:0] flags_q, flags_d;
    logic       logic_op;

    // AND/ORR have no carry/overflow meaning, so C and V are kept.
    assign logic_op = (cmd_alu == ALU_AND) || (cmd_alu == ALU_ORR);

    always_comb begin
        flags_d = flags_q;
        if ((state_q == S_EXECR || state_q == S_EXECI) && cmd_ok && l_bit)
            flags_d = logic_op ? {ALU_Flags[3:2], flags_q[1:0]} : ALU_Flags;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) flags_q <= 4'b0000;
        else        flags_q <= flags_d;
    end

    cond_check u_cond_check (
        .cond_i    (Instr[31:28]),
        .flags_i   (flags_q),
        .cond_ex_o (cond_ex)
    );

    assign Flags       = flags_q;
    assign unused_bits = ^Instr[19:0];
`else
    assign cond_ex     = 1'b1;
    assign Flags       = 4'b0000;
    assign unused_bits = ^{Instr[31:28], Instr[19:0], ALU_Flags};
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control; expectations adapt to COND_EXEC_EN.
module tb_multicycle_control;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic [31:0] Instr;
    logic [3:0]  ALU_Flags;
    logic        MemReady;
    logic        MemReq, MemWrite, IRWrite, PCWrite, AdrSrc, RegWrite, ALUSrcA;
    logic [1:0]  RegSrc, ImmSrc, ALUSrcB, ALU_Code, ResultSrc;
    logic [3:0]  Flags;

    int total = 0;
    int bad   = 0;

`ifdef COND_EXEC_EN
    localparam bit CE = 1'b1;
`else
    localparam bit CE = 1'b0;
`endif

    multicycle_control dut (
        .CLK(CLK), .RST_N(RST_N), .Instr(Instr), .ALU_Flags(ALU_Flags),
        .MemReady(MemReady), .MemReq(MemReq), .MemWrite(MemWrite),
        .IRWrite(IRWrite), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
        .RegWrite(RegWrite), .RegSrc(RegSrc), .ImmSrc(ImmSrc),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALU_Code(ALU_Code),
        .ResultSrc(ResultSrc), .Flags(Flags)
    );

    always #5 CLK = ~CLK;

    // {MemReq,MemWrite,IRWrite,PCWrite,AdrSrc,RegWrite, RegSrc, ImmSrc, ALUSrcA, ALUSrcB, ALU_Code, ResultSrc}
    logic [16:0] outs;
    assign outs = {MemReq, MemWrite, IRWrite, PCWrite, AdrSrc, RegWrite,
                   RegSrc, ImmSrc, ALUSrcA, ALUSrcB, ALU_Code, ResultSrc};

    localparam logic [16:0] V_ZERO    = 17'b0;
    localparam logic [16:0] V_FETCH   = {6'b101100, 2'b00, 2'b00, 1'b1, 2'b10, 2'b00, 2'b00};
    localparam logic [16:0] V_FETCH_W = {6'b100000, 2'b00, 2'b00, 1'b1, 2'b10, 2'b00, 2'b00};
    localparam logic [16:0] V_DEC_DP  = 17'b0;
    localparam logic [16:0] V_DEC_MEM = {6'b000000, 2'b10, 2'b01, 1'b0, 2'b00, 2'b00, 2'b00};
    localparam logic [16:0] V_DEC_BR  = {6'b000000, 2'b01, 2'b10, 1'b0, 2'b00, 2'b00, 2'b00};
    localparam logic [16:0] V_EXR_ADD = 17'b0;
    localparam logic [16:0] V_EXR_AND = {6'b000000, 2'b00, 2'b00, 1'b0, 2'b00, 2'b10, 2'b00};
    localparam logic [16:0] V_EXR_ORR = {6'b000000, 2'b00, 2'b00, 1'b0, 2'b00, 2'b11, 2'b00};
    localparam logic [16:0] V_EXI_SUB = {6'b000000, 2'b00, 2'b00, 1'b0, 2'b01, 2'b01, 2'b00};
    localparam logic [16:0] V_ALUWB   = {6'b000001, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00};
    localparam logic [16:0] V_MEMADR  = {6'b000000, 2'b00, 2'b01, 1'b0, 2'b01, 2'b00, 2'b00};
    localparam logic [16:0] V_MEMRD   = {6'b100010, 11'b0};
    localparam logic [16:0] V_MEMWB   = {6'b000001, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 2'b01};
    localparam logic [16:0] V_MEMWR   = {6'b110010, 11'b0};
    localparam logic [16:0] V_BRANCH  = {6'b000100, 2'b00, 2'b10, 1'b1, 2'b01, 2'b00, 2'b10};

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RST_N = 1'b0; Instr = 32'h0; ALU_Flags = 4'h0; MemReady = 1'b0;
        repeat (2) tick();
        total++;
        if (outs !== V_ZERO) begin bad++; $display("FAIL reset_outs got=%h exp=%h", outs, V_ZERO); end
        total++;
        if (Flags !== 4'b0000) begin bad++; $display("FAIL reset_flags got=%b exp=0000", Flags); end
        MemReady = 1'b1;
        RST_N = 1'b1;
        total++;
        if (outs !== V_ZERO) begin bad++; $display("FAIL reset_idle got=%h exp=%h", outs, V_ZERO); end
        tick();
        total++;
        if (outs !== V_FETCH) begin bad++; $display("FAIL reset_fetch got=%h exp=%h", outs, V_FETCH); end
    endtask

    task automatic test_add();
        logic [16:0] seq[$];
        Instr = 32'hE0821003; ALU_Flags = 4'b1111;
        seq = '{V_FETCH, V_DEC_DP, V_EXR_ADD, V_ALUWB, V_FETCH};
        for (int i = 0; i < seq.size(); i++) begin
            if (i > 0) tick();
            total++;
            if (outs !== seq[i]) begin bad++; $display("FAIL add cyc%0d got=%h exp=%h", i, outs, seq[i]); end
        end
        total++;
        if (Flags !== 4'b0000) begin bad++; $display("FAIL add_flags got=%b exp=0000", Flags); end
    endtask

    task automatic test_logic_flags();
        logic [16:0] seq[$];
        logic [31:0] ins[4];
        logic [3:0]  alu[4];
        logic [16:0] ex[4];
        logic [3:0]  fx[4];
        ins = '{32'hE2500001, 32'hE0110002, 32'hE1810002, 32'hE1910002};
        alu = '{4'b0011, 4'b1100, 4'b0000, 4'b0001};
        ex  = '{V_EXI_SUB, V_EXR_AND, V_EXR_ORR, V_EXR_ORR};
        fx  = '{CE ? 4'b0011 : 4'b0000, CE ? 4'b1111 : 4'b0000,
                CE ? 4'b1111 : 4'b0000, CE ? 4'b0011 : 4'b0000};
        for (int k = 0; k < 4; k++) begin
            Instr = ins[k]; ALU_Flags = alu[k];
            seq = '{V_FETCH, V_DEC_DP, ex[k], V_ALUWB, V_FETCH};
            for (int i = 0; i < seq.size(); i++) begin
                if (i > 0) tick();
                total++;
                if (outs !== seq[i]) begin bad++; $display("FAIL logic%0d cyc%0d got=%h exp=%h", k, i, outs, seq[i]); end
            end
            total++;
            if (Flags !== fx[k]) begin bad++; $display("FAIL logic%0d_flags got=%b exp=%b", k, Flags, fx[k]); end
        end
    endtask

    task automatic test_cond_ge_hi();
        logic [16:0] seq[$];
        Instr = 32'hA0821003; ALU_Flags = 4'b0000;
        if (CE) seq = '{V_FETCH, V_DEC_DP, V_FETCH};
        else    seq = '{V_FETCH, V_DEC_DP, V_EXR_ADD, V_ALUWB, V_FETCH};
        for (int i = 0; i < seq.size(); i++) begin
            if (i > 0) tick();
            total++;
            if (outs !== seq[i]) begin bad++; $display("FAIL cond_ge cyc%0d got=%h exp=%h", i, outs, seq[i]); end
        end
        Instr = 32'h80821003;
        seq = '{V_FETCH, V_DEC_DP, V_EXR_ADD, V_ALUWB, V_FETCH};
        for (int i = 0; i < seq.size(); i++) begin
            if (i > 0) tick();
            total++;
            if (outs !== seq[i]) begin bad++; $display("FAIL cond_hi cyc%0d got=%h exp=%h", i, outs, seq[i]); end
        end
    endtask

    task automatic test_flags_branch();
        logic [16:0] seq[$];
        Instr = 32'hE2500001; ALU_Flags = 4'b0100;
        seq = '{V_FETCH, V_DEC_DP, V_EXI_SUB, V_ALUWB, V_FETCH};
        for (int i = 0; i < seq.size(); i++) begin
            if (i > 0) tick();
            total++;
            if (outs !== seq[i]) begin bad++; $display("FAIL subs cyc%0d got=%h exp=%h", i, outs, seq[i]); end
        end
        total++;
        if (Flags !== (CE ? 4'b0100 : 4'b0000)) begin bad++; $display("FAIL subs_flags got=%b", Flags); end
        Instr = 32'h0A000002; ALU_Flags = 4'b0000;
        seq = '{V_FETCH, V_DEC_BR, V_BRANCH, V_FETCH};
        for (int i = 0; i < seq.size(); i++) begin
            if (i > 0) tick();
            total++;
            if (outs !== seq[i]) begin bad++; $display("FAIL beq cyc%0d got=%h exp=%h", i, outs, seq[i]); end
        end
    endtask

    task automatic test_cond_fail();
        logic [16:0] seq[$];
        logic [31:0] ins[2];
        ins = '{32'h10821003, 32'hF0821003};
        for (int k = 0; k < 2; k++) begin
            Instr = ins[k]; ALU_Flags = 4'b0000;
            if (CE) seq = '{V_FETCH, V_DEC_DP, V_FETCH};
            else    seq = '{V_FETCH, V_DEC_DP, V_EXR_ADD, V_ALUWB, V_FETCH};
            for (int i = 0; i < seq.size(); i++) begin
                if (i > 0) tick();
                total++;
                if (outs !== seq[i]) begin bad++; $display("FAIL condfail%0d cyc%0d got=%h exp=%h", k, i, outs, seq[i]); end
            end
        end
    endtask

    task automatic test_ldr_stall();
        logic [16:0] seq[$];
        Instr = 32'hE5954008; ALU_Flags = 4'b0000; MemReady = 1'b1;
        seq = '{V_FETCH, V_DEC_MEM, V_MEMADR};
        for (int i = 0; i < seq.size(); i++) begin
            if (i > 0) tick();
            total++;
            if (outs !== seq[i]) begin bad++; $display("FAIL ldr cyc%0d got=%h exp=%h", i, outs, seq[i]); end
        end
        MemReady = 1'b0;
        for (int w = 0; w < 3; w++) begin
            tick();
            total++;
            if (outs !== V_MEMRD) begin bad++; $display("FAIL ldr_wait%0d got=%h exp=%h", w, outs, V_MEMRD); end
        end
        MemReady = 1'b1;
        #1;
        total++;
        if (outs !== V_MEMRD) begin bad++; $display("FAIL ldr_ready got=%h exp=%h", outs, V_MEMRD); end
        tick();
        total++;
        if (outs !== V_MEMWB) begin bad++; $display("FAIL ldr_wb got=%h exp=%h", outs, V_MEMWB); end
        tick();
        total++;
        if (outs !== V_FETCH) begin bad++; $display("FAIL ldr_end got=%h exp=%h", outs, V_FETCH); end
    endtask

    task automatic test_str_stall();
        logic [16:0] seq[$];
        Instr = 32'hE5854008; MemReady = 1'b1;
        seq = '{V_FETCH, V_DEC_MEM, V_MEMADR};
        for (int i = 0; i < seq.size(); i++) begin
            if (i > 0) tick();
            total++;
            if (outs !== seq[i]) begin bad++; $display("FAIL str cyc%0d got=%h exp=%h", i, outs, seq[i]); end
        end
        MemReady = 1'b0;
        for (int w = 0; w < 2; w++) begin
            tick();
            total++;
            if (outs !== V_MEMWR) begin bad++; $display("FAIL str_wait%0d got=%h exp=%h", w, outs, V_MEMWR); end
        end
        MemReady = 1'b1;
        tick();
        total++;
        if (outs !== V_FETCH) begin bad++; $display("FAIL str_end got=%h exp=%h", outs, V_FETCH); end
    endtask

    task automatic test_bad_cmd();
        logic [16:0] seq[$];
        Instr = 32'hE1F00000; ALU_Flags = 4'b1111;
        seq = '{V_FETCH, V_DEC_DP, V_EXR_ADD, V_FETCH};
        for (int i = 0; i < seq.size(); i++) begin
            if (i > 0) tick();
            total++;
            if (outs !== seq[i]) begin bad++; $display("FAIL badcmd cyc%0d got=%h exp=%h", i, outs, seq[i]); end
        end
        total++;
        if (Flags !== (CE ? 4'b0100 : 4'b0000)) begin bad++; $display("FAIL badcmd_flags got=%b", Flags); end
    endtask

    task automatic test_reset_mid();
        MemReady = 1'b0;
        tick();
        total++;
        if (outs !== V_FETCH_W) begin bad++; $display("FAIL mid_fetch_wait got=%h exp=%h", outs, V_FETCH_W); end
        #2;
        RST_N = 1'b0;
        #1;
        total++;
        if (outs !== V_ZERO) begin bad++; $display("FAIL mid_reset_outs got=%h exp=%h", outs, V_ZERO); end
        total++;
        if (Flags !== 4'b0000) begin bad++; $display("FAIL mid_reset_flags got=%b exp=0000", Flags); end
        tick();
        RST_N = 1'b1;
        MemReady = 1'b1;
        total++;
        if (outs !== V_ZERO) begin bad++; $display("FAIL mid_idle got=%h exp=%h", outs, V_ZERO); end
        tick();
        total++;
        if (outs !== V_FETCH) begin bad++; $display("FAIL mid_refetch got=%h exp=%h", outs, V_FETCH); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_logic_flags();
        test_cond_ge_hi();
        test_flags_branch();
        test_cond_fail();
        test_ldr_stall();
        test_str_stall();
        test_bad_cmd();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
